gf180mcu_gpio_pad_ctrl: RTL

//  Core-side controller for N gf180mcu_fd_io__bi_t bidirectional pads; sits directly upstream of the pad ring.

---
 rtl/gf180mcu_gpio_pad_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gf180mcu_gpio_pad_ctrl.sv
// Core-side controller for gf180mcu bi_t pads: per-pad config registers drive the pad pins, and
// every pad_y is synchronised, debounced and turned into edge pulses plus sticky interrupt flags.
module gf180mcu_gpio_pad_ctrl #(
    parameter int  N           = 8,
    parameter int  SYNC_STAGES = 2,
    parameter int  DB_W        = 8,
    localparam int SW          = (N > 1) ? $clog2(N) : 1,
    localparam int CW          = DB_W + 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  out_data,
    input  logic [N-1:0]  out_en,
    output logic [N-1:0]  in_data,
    output logic [N-1:0]  in_rise,
    output logic [N-1:0]  in_fall,
    output logic          irq,
    output logic [N-1:0]  irq_status,
    input  logic [N-1:0]  irq_clr,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_sel,
    input  logic [CW-1:0] cfg_wdata,
    output logic [CW-1:0] cfg_rdata,
    output logic [N-1:0]  pad_a,
    output logic [N-1:0]  pad_oe,
    output logic [N-1:0]  pad_ie,
    output logic [N-1:0]  pad_pu,
    output logic [N-1:0]  pad_pd,
    output logic [N-1:0]  pad_sl,
    output logic [N-1:0]  pad_cs,
    output logic [N-1:0]  pad_pdrv0,
    output logic [N-1:0]  pad_pdrv1,
    input  logic [N-1:0]  pad_y
);
    localparam int IE_B  = DB_W;
    localparam int PU_B  = DB_W + 1;
    localparam int PD_B  = DB_W + 2;
    localparam int SL_B  = DB_W + 3;
    localparam int CS_B  = DB_W + 4;
    localparam int PDRV0 = DB_W + 5;
    localparam int PDRV1 = DB_W + 6;
    localparam int REN_B = DB_W + 7;
    localparam int FEN_B = DB_W + 8;
    localparam logic [CW-1:0] CFG_RST = (CW'(1) << PD_B) | (CW'(1) << SL_B);

    logic [CW-1:0] cfg_reg [N];
    logic [CW-1:0] wdata_fix;
    logic          sel_ok;
    logic [N-1:0]  ie_vec, pu_vec, pd_vec, sl_vec, cs_vec;
    logic [N-1:0]  pdrv0_vec, pdrv1_vec, rise_en_vec, fall_en_vec;

    assign sel_ok    = (int'(cfg_sel) < N);
    assign cfg_rdata = sel_ok ? cfg_reg[cfg_sel] : '0;

    // Pull-down takes priority so the pad is never pulled both ways at once.
    always_comb begin
        wdata_fix = cfg_wdata;
        if (cfg_wdata[PU_B] && cfg_wdata[PD_B]) begin
            wdata_fix[PU_B] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cfg_reg[i] <= CFG_RST;
            end
        end else if (cfg_we && sel_ok) begin
            cfg_reg[cfg_sel] <= wdata_fix;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pad
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [DB_W-1:0]        cnt_reg;
            logic                   in_data_reg, in_rise_reg, in_fall_reg;
            logic [DB_W:0]          t_eff;
            logic                   sync_bit, mismatch, cnt_done;

            assign ie_vec[gi]      = cfg_reg[gi][IE_B];
            assign pu_vec[gi]      = cfg_reg[gi][PU_B];
            assign pd_vec[gi]      = cfg_reg[gi][PD_B];
            assign sl_vec[gi]      = cfg_reg[gi][SL_B];
            assign cs_vec[gi]      = cfg_reg[gi][CS_B];
            assign pdrv0_vec[gi]   = cfg_reg[gi][PDRV0];
            assign pdrv1_vec[gi]   = cfg_reg[gi][PDRV1];
            assign rise_en_vec[gi] = cfg_reg[gi][REN_B];
            assign fall_en_vec[gi] = cfg_reg[gi][FEN_B];

            // A threshold of zero behaves like one so every change needs at least one stable cycle.
            assign t_eff    = (cfg_reg[gi][DB_W-1:0] == '0) ? (DB_W+1)'(1) : {1'b0, cfg_reg[gi][DB_W-1:0]};
            assign sync_bit = sync_reg[SYNC_STAGES-1];
            assign mismatch = (sync_bit != in_data_reg);
            assign cnt_done = (({1'b0, cnt_reg} + (DB_W+1)'(1)) >= t_eff);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg    <= '0;
                    cnt_reg     <= '0;
                    in_data_reg <= 1'b0;
                    in_rise_reg <= 1'b0;
                    in_fall_reg <= 1'b0;
                end else if (!ie_vec[gi]) begin
                    sync_reg    <= '0;
                    cnt_reg     <= '0;
                    in_rise_reg <= 1'b0;
                    in_fall_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], pad_y[gi]};
                    in_rise_reg <= 1'b0;
                    in_fall_reg <= 1'b0;
                    if (!mismatch) begin
                        cnt_reg <= '0;
                    end else if (cnt_done) begin
                        cnt_reg     <= '0;
                        in_data_reg <= sync_bit;
                        in_rise_reg <= sync_bit;
                        in_fall_reg <= !sync_bit;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign in_data[gi] = in_data_reg;
            assign in_rise[gi] = in_rise_reg;
            assign in_fall[gi] = in_fall_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_a      <= '0;
            pad_oe     <= '0;
            pad_ie     <= '0;
            pad_pu     <= '0;
            pad_pd     <= '1;
            pad_sl     <= '1;
            pad_cs     <= '0;
            pad_pdrv0  <= '0;
            pad_pdrv1  <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            pad_a      <= out_data;
            pad_oe     <= out_en;
            pad_ie     <= ie_vec;
            pad_pu     <= pu_vec;
            pad_pd     <= pd_vec;
            pad_sl     <= sl_vec;
            pad_cs     <= cs_vec;
            pad_pdrv0  <= pdrv0_vec;
            pad_pdrv1  <= pdrv1_vec;
            // Set terms are OR-ed after the clear so a coincident edge keeps the flag.
            irq_status <= (irq_status & ~irq_clr) | (in_rise & rise_en_vec) | (in_fall & fall_en_vec);
            irq        <= |irq_status;
        end
    end
endmodule
